// File: rtl/led_pkg.sv
// Package shared by the HUB75 scan controller.
//   DDR_*        : {fall,rise} pairs handed to the ddr output cells
//   scan_state_t : scan sequencer states
//   FRAME_BITS   : width of the frame counter seen by the painter
package led_pkg;

  localparam logic [1:0] DDR_LOW   = 2'b00;
  localparam logic [1:0] DDR_HIGH  = 2'b11;
  localparam logic [1:0] DDR_PULSE = 2'b10;  // low first half, rises mid-cycle

  localparam int FRAME_BITS = 13;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLANK,
    LATCH
  } scan_state_t;

endpackage

// File: rtl/led_bcm_timer.sv
// BCM on-time down-counter.
//   clk, reset  : pll clock, async active-high reset
//   i_load      : load i_load_val this cycle (priority over counting)
//   i_load_val  : display cycles for the plane just latched (0 clears)
//   o_count     : remaining display cycles
//   o_zero      : o_count == 0
// Counts down by one per cycle and saturates at zero.
module led_bcm_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic [TW-1:0] o_count,
  output logic          o_zero
);

  logic [TW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// Scan sequencer for a 1/32-scan HUB75 panel.
// Walks row pairs and BCM bit planes, fetches pixel bits from the pixel
// source, shifts them out and drives the addr/rgb/sclk/latch/blank ddr pairs.
//   clk, reset         : pll clock, async active-high reset
//   enable             : run scanning; sampled in LATCH, low parks blanked
//   px_req/px_x/px_row/px_plane : pixel fetch strobe and address
//   px_rgb0/px_rgb1    : fetched pixel bits, valid one cycle after px_req
//   led_rgb0/led_rgb1  : registered shift data, upper/lower half
//   led_addr           : displayed row address (changes only in BLANK)
//   sclk/latch/blank   : ddr pairs {fall,rise}
//   frame/frame_done   : frame counter and its per-frame pulse; the pulse and
//                        the increment appear in the cycle after the final LATCH
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int ROW_BITS = 5,
  parameter int PLANES   = 4,
  parameter int BASE_ON  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      px_req,
  output logic [$clog2(WIDTH)-1:0]  px_x,
  output logic [ROW_BITS-1:0]       px_row,
  output logic [$clog2(PLANES)-1:0] px_plane,
  input  logic [2:0]                px_rgb0,
  input  logic [2:0]                px_rgb1,
  output logic [2:0]                led_rgb0,
  output logic [2:0]                led_rgb1,
  output logic [ROW_BITS-1:0]       led_addr,
  output logic [1:0]                sclk,
  output logic [1:0]                latch,
  output logic [1:0]                blank,
  output logic [FRAME_BITS-1:0]     frame,
  output logic                      frame_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int PW = $clog2(PLANES);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int TW = $clog2((BASE_ON << (PLANES - 1)) + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH + 1);  // final SHIFT cycle
  localparam logic [CW-1:0] CNT_WIDTH  = CW'(WIDTH);
  localparam logic [CW-1:0] REQ_LAST   = CW'(WIDTH - 1);  // final fetch cycle
  localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);

  scan_state_t           r_state;
  logic [CW-1:0]         r_cnt;
  logic [ROW_BITS-1:0]   r_row;
  logic [PW-1:0]         r_plane;
  logic                  r_px_req;
  logic [XW-1:0]         r_px_x;
  logic [2:0]            r_led_rgb0;
  logic [2:0]            r_led_rgb1;
  logic [ROW_BITS-1:0]   r_led_addr;
  logic [1:0]            r_sclk;
  logic [1:0]            r_latch;
  logic [1:0]            r_blank;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_frame_done;

  logic [TW-1:0] w_on_count;
  logic          w_on_zero;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_expiring;
  logic          w_data_slot;
  logic          w_last_slot;

  // The timer is loaded in every LATCH; a disabling LATCH clears it so the
  // plane just latched is never displayed.
  assign w_load     = (r_state == LATCH);
  assign w_load_val = enable ? (TW'(BASE_ON) << r_plane) : '0;

  // Timer reads zero next cycle: SHIFT/WAIT hand over to BLANK exactly in the
  // first cycle with no display time left, and blank rises in step with it.
  assign w_expiring = w_on_zero || (w_on_count == TW'(1));

  // SHIFT cycles 1..WIDTH receive the pixel requested one cycle earlier.
  assign w_data_slot = (r_cnt != '0) && (r_cnt <= CNT_WIDTH);
  assign w_last_slot = (&r_row) && (r_plane == LAST_PLANE);

  led_bcm_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_on_count),
    .o_zero     (w_on_zero)
  );

  // NOTE: outputs are registered, so each branch assigns the values wanted in
  // the *next* cycle; pulse outputs get a default first so nothing holds over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_plane      <= '0;
      r_px_req     <= 1'b0;
      r_px_x       <= '0;
      r_led_rgb0   <= '0;
      r_led_rgb1   <= '0;
      r_led_addr   <= '0;
      r_sclk       <= DDR_LOW;
      r_latch      <= DDR_LOW;
      r_blank      <= DDR_HIGH;
      r_frame      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_latch      <= DDR_LOW;
      r_sclk       <= DDR_LOW;

      case (r_state)
        IDLE: begin
          r_blank  <= DDR_HIGH;
          r_px_req <= 1'b0;
          if (enable) begin
            r_state  <= SHIFT;
            r_cnt    <= '0;
            r_px_req <= 1'b1;
            r_px_x   <= '0;
          end
        end

        SHIFT: begin
          r_cnt    <= r_cnt + 1'b1;
          r_px_req <= (r_cnt < REQ_LAST);
          if (r_cnt < REQ_LAST) begin
            r_px_x <= XW'(r_cnt + 1'b1);
          end
          if (w_data_slot) begin
            r_led_rgb0 <= px_rgb0;
            r_led_rgb1 <= px_rgb1;
            r_sclk     <= DDR_PULSE;  // clocks this data out next cycle
          end
          // Previous plane keeps displaying while this one shifts in.
          r_blank <= w_expiring ? DDR_HIGH : DDR_LOW;
          if (r_cnt == CNT_LAST) begin
            r_state <= w_expiring ? BLANK : WAIT;
          end
        end

        WAIT: begin
          r_blank <= w_expiring ? DDR_HIGH : DDR_LOW;
          if (w_expiring) begin
            r_state <= BLANK;
          end
        end

        BLANK: begin
          r_led_addr <= r_row;
          r_latch    <= DDR_HIGH;
          r_blank    <= DDR_HIGH;
          r_state    <= LATCH;
        end

        LATCH: begin
          if (w_last_slot) begin
            r_frame      <= r_frame + 1'b1;
            r_frame_done <= 1'b1;
          end
          if (enable) begin
            r_state  <= SHIFT;
            r_cnt    <= '0;
            r_px_req <= 1'b1;
            r_px_x   <= '0;
            r_blank  <= DDR_LOW;  // freshly loaded plane starts displaying
            if (r_plane == LAST_PLANE) begin
              r_plane <= '0;
              r_row   <= r_row + 1'b1;
            end else begin
              r_plane <= r_plane + 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_row   <= '0;
            r_plane <= '0;
            r_blank <= DDR_HIGH;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign px_req     = r_px_req;
  assign px_x       = r_px_x;
  assign px_row     = r_row;
  assign px_plane   = r_plane;
  assign led_rgb0   = r_led_rgb0;
  assign led_rgb1   = r_led_rgb1;
  assign led_addr   = r_led_addr;
  assign sclk       = r_sclk;
  assign latch      = r_latch;
  assign blank      = r_blank;
  assign frame      = r_frame;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with WIDTH=4, ROW_BITS=1, PLANES=2,
// BASE_ON=8. Cycle e is the interval after the e-th rising edge following
// reset release; outputs are sampled 1 time unit after that edge.
// Hand-derived timeline: shifts start at 1,9,19,37,47; LATCH at 8,18,36,46,64;
// display (blank=00) on 9-16, 19-34, 37-44, 47-62; frame_done at 47.
module tb_led_scan_ctrl;

  localparam int WIDTH    = 4;
  localparam int ROW_BITS = 1;
  localparam int PLANES   = 2;
  localparam int BASE_ON  = 8;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          px_req;
  logic [1:0]    px_x;
  logic [0:0]    px_row;
  logic [0:0]    px_plane;
  logic [2:0]    px_rgb0;
  logic [2:0]    px_rgb1;
  logic [2:0]    led_rgb0;
  logic [2:0]    led_rgb1;
  logic [0:0]    led_addr;
  logic [1:0]    sclk;
  logic [1:0]    latch;
  logic [1:0]    blank;
  logic [12:0]   frame;
  logic          frame_done;

  led_scan_ctrl #(
    .WIDTH    (WIDTH),
    .ROW_BITS (ROW_BITS),
    .PLANES   (PLANES),
    .BASE_ON  (BASE_ON)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .px_req     (px_req),
    .px_x       (px_x),
    .px_row     (px_row),
    .px_plane   (px_plane),
    .px_rgb0    (px_rgb0),
    .px_rgb1    (px_rgb1),
    .led_rgb0   (led_rgb0),
    .led_rgb1   (led_rgb1),
    .led_addr   (led_addr),
    .sclk       (sclk),
    .latch      (latch),
    .blank      (blank),
    .frame      (frame),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int shift_start[5] = '{1, 9, 19, 37, 47};
  int latch_cyc[5]   = '{8, 18, 36, 46, 64};
  int addr_exp[5]    = '{0, 0, 1, 1, 0};
  logic [2:0] rgb0_tab[4] = '{3'b001, 3'b011, 3'b101, 3'b110};
  logic [2:0] rgb1_tab[4] = '{3'b110, 3'b100, 3'b010, 3'b001};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_blank"},  32'(blank), 32'd3);
    check({tag, "_latch"},  32'(latch), 32'd0);
    check({tag, "_sclk"},   32'(sclk), 32'd0);
    check({tag, "_rgb0"},   32'(led_rgb0), 32'd0);
    check({tag, "_rgb1"},   32'(led_rgb1), 32'd0);
    check({tag, "_addr"},   32'(led_addr), 32'd0);
    check({tag, "_frame"},  32'(frame), 32'd0);
    check({tag, "_fdone"},  32'(frame_done), 32'd0);
    check({tag, "_pxreq"},  32'(px_req), 32'd0);
    check({tag, "_pxrow"},  32'(px_row), 32'd0);
    check({tag, "_pxpln"},  32'(px_plane), 32'd0);
  endtask

  function automatic logic [1:0] exp_sclk(input int e);
    for (int i = 0; i < 5; i++)
      if (e - shift_start[i] >= 2 && e - shift_start[i] <= 5) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_req(input int e);
    for (int i = 0; i < 5; i++)
      if (e - shift_start[i] >= 0 && e - shift_start[i] <= 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_blank(input int e);
    if ((e >= 9 && e <= 16) || (e >= 19 && e <= 34) ||
        (e >= 37 && e <= 44) || (e >= 47 && e <= 62)) return 2'b00;
    return 2'b11;
  endfunction

  initial begin
    int  seen;
    int  hit_cyc;
    int  lat_cyc;

    reset   = 1'b1;
    enable  = 1'b1;
    px_rgb0 = 3'b000;
    px_rgb1 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    // Tests 1-4: first frame and the start of the next one.
    for (int e = 1; e <= 64; e++) begin
      tick();
      check("sclk", 32'(sclk), 32'(exp_sclk(e)));
      check("px_req", 32'(px_req), 32'(exp_req(e)));
      check("blank", 32'(blank), 32'(exp_blank(e)));
      check("sclk_latch_excl", 32'((sclk != 2'b00) && (latch != 2'b00)), 32'd0);
      check("frame_done", 32'(frame_done), 32'(e == 47));
      if (e <= 4) check("px_x", 32'(px_x), 32'(e - 1));
      if (e >= 3 && e <= 6) begin
        check("led_rgb0", 32'(led_rgb0), 32'(rgb0_tab[e-3]));
        check("led_rgb1", 32'(led_rgb1), 32'(rgb1_tab[e-3]));
      end
      begin
        logic is_latch;
        is_latch = 1'b0;
        for (int i = 0; i < 5; i++)
          if (latch_cyc[i] == e) begin
            is_latch = 1'b1;
            check("led_addr", 32'(led_addr), 32'(addr_exp[i]));
          end
        check("latch", 32'(latch), is_latch ? 32'd3 : 32'd0);
      end
      if (e == 9)  check("px_plane_p1", 32'(px_plane), 32'd1);
      if (e == 18) check("px_row_r0", 32'(px_row), 32'd0);
      if (e == 19) check("px_row_r1", 32'(px_row), 32'd1);
      if (e == 46) check("frame_pre", 32'(frame), 32'd0);
      if (e == 47) begin
        check("frame_post", 32'(frame), 32'd1);
        check("px_row_wrap", 32'(px_row), 32'd0);
      end
      if (e >= 2 && e <= 5) begin
        px_rgb0 = rgb0_tab[e-2];
        px_rgb1 = rgb1_tab[e-2];
      end else begin
        px_rgb0 = 3'b000;
        px_rgb1 = 3'b000;
      end
    end

    // Test 5: preload 8191 mid-frame; the next frame end wraps it to 0.
    tick();
    tick();
    force dut.r_frame = 13'd8191;
    tick();
    release dut.r_frame;
    seen = 0;
    hit_cyc = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        seen = 1;
        hit_cyc = cyc;
      end
    end
    check("wrap_seen", 32'(seen), 32'd1);
    check("wrap_cycle", 32'(hit_cyc), 32'd103);
    check("wrap_frame", 32'(frame), 32'd0);

    // Test 6: drop enable mid-SHIFT; scanning finishes to LATCH, then parks.
    tick();
    tick();
    enable = 1'b0;
    seen = 0;
    lat_cyc = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      if (latch === 2'b11) begin
        seen = 1;
        lat_cyc = cyc;
      end
    end
    check("dis_latch_seen", 32'(seen), 32'd1);
    check("dis_latch_cycle", 32'(lat_cyc), 32'd120);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle_blank", 32'(blank), 32'd3);
      check("idle_pxreq", 32'(px_req), 32'd0);
      check("idle_sclk", 32'(sclk), 32'd0);
    end
    check("frame_kept", 32'(frame), 32'd0);

    // Restart from row 0 / plane 0 with the timer cleared: stays blanked.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("restart_blank", 32'(blank), 32'd3);
      check("restart_row", 32'(px_row), 32'd0);
      check("restart_plane", 32'(px_plane), 32'd0);
    end
    check("restart_latch", 32'(latch), 32'd3);
    check("restart_addr", 32'(led_addr), 32'd0);

    // Into WAIT of the next plane (display running), then async reset.
    repeat (7) tick();
    check("wait_blank", 32'(blank), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
